// File: rtl/cos_acc_pkg.sv
// Shared types and constants for the cosine-accumulate sequencer.
package cos_acc_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Datapath latency split: cosine core followed by the FP accumulator
  localparam int INNER_LAT = 43;
  localparam int ACC_LAT   = 8;
  localparam int DEF_LAT   = INNER_LAT + ACC_LAT;

  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/cos_acc_sequencer_if.sv
// Host command/sample handshake, datapath drive and result reporting.
interface cos_acc_sequencer_if
  import cos_acc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             pipe_en;
  logic [31:0]      pipe_x;
  logic             pipe_n;
  logic [31:0]      pipe_r;
  logic [31:0]      result;
  logic             done;
  logic             busy;

  // Host side plus datapath model: drives commands, samples and accumulator output
  modport master (
    output cmd_valid, cmd_len, in_valid, in_data, pipe_r,
    input  cmd_ready, in_ready, pipe_en, pipe_x, pipe_n, result, done, busy
  );

  // Sequencer side
  modport slave (
    input  cmd_valid, cmd_len, in_valid, in_data, pipe_r,
    output cmd_ready, in_ready, pipe_en, pipe_x, pipe_n, result, done, busy
  );

endinterface

// File: rtl/cos_acc_sequencer_tag_delay_line.sv
// Fixed-depth 1-bit delay line that only advances on enabled edges, so a
// tag stays aligned with its operand through a stall-capable pipeline.
module tag_delay_line #(
  parameter int DEPTH = 51
) (
  input  logic clock,
  input  logic clear,
  input  logic en,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  // Shift in a new tag on each enabled edge; clear wins over enable
  always_ff @(posedge clock) begin
    if (clear) begin
      sr <= '0;
    end else if (en) begin
      sr <= DEPTH'({sr, din});
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/cos_acc_sequencer.sv
// Job sequencer for the cosine-accumulate datapath: streams a counted job
// of FP32 samples, flags the restart sample, drains the pipeline and
// latches the final sum.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command; cmd_ready high
// ST_FEED  | accepting samples; datapath advances only when in_valid
// ST_DRAIN | pushing zeros until the last sample's tag emerges
// ST_DONE  | one-cycle done pulse, result holds the job sum
module cos_acc_sequencer
  import cos_acc_pkg::*;
#(
  parameter int LAT   = DEF_LAT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic               clock,
  input logic               reset,
  cos_acc_sequencer_if.slave bus
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic             first_q, first_d;
  logic [31:0]      result_q, result_d;

  logic        cmd_ready;
  logic        in_ready;
  logic        pipe_en;
  logic [31:0] pipe_x;
  logic        pipe_n;
  logic        done;
  logic        tag_in;
  logic        tag_out;

  // State and job bookkeeping registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      first_q     <= 1'b0;
      result_q    <= FP_ZERO;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      result_q    <= result_d;
    end
  end

  // Next-state, datapath drive and handshake outputs
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    result_d    = result_q;
    cmd_ready   = 1'b0;
    in_ready    = 1'b0;
    pipe_en     = 1'b0;
    pipe_x      = FP_ZERO;
    pipe_n      = 1'b0;
    tag_in      = 1'b0;
    done        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          if (bus.cmd_len != '0) begin
            remaining_d = bus.cmd_len;
            first_d     = 1'b1;
            state_d     = ST_FEED;
          end else begin
            // An empty job reports a zero sum without touching the datapath
            result_d = FP_ZERO;
            state_d  = ST_DONE;
          end
        end
      end

      ST_FEED: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          pipe_en     = 1'b1;
          pipe_x      = bus.in_data;
          pipe_n      = first_q;
          first_d     = 1'b0;
          remaining_d = remaining_q - CNT_W'(1);
          // Only the final sample is tagged; its arrival at the
          // accumulator output marks the complete sum
          tag_in      = (remaining_q == CNT_W'(1));
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        pipe_en = 1'b1;
        if (tag_out) begin
          result_d = bus.pipe_r;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  tag_delay_line #(
    .DEPTH (LAT)
  ) u_tag (
    .clock (clock),
    .clear (reset),
    .en    (pipe_en),
    .din   (tag_in),
    .dout  (tag_out)
  );

  assign bus.cmd_ready = cmd_ready;
  assign bus.in_ready  = in_ready;
  assign bus.pipe_en   = pipe_en;
  assign bus.pipe_x    = pipe_x;
  assign bus.pipe_n    = pipe_n;
  assign bus.result    = result_q;
  assign bus.done      = done;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cos_acc_sequencer.sv
// Scoreboard bench for cos_acc_sequencer with a behavioural cos+accumulate
// datapath model and randomized jobs.
module tb_cos_acc_sequencer;
  import cos_acc_pkg::*;

  localparam int LAT   = INNER_LAT + ACC_LAT;
  localparam int CNT_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  cos_acc_sequencer_if #(.CNT_W(CNT_W)) bus ();

  cos_acc_sequencer #(.LAT(LAT), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Edge counter: at a negedge, cyc is the index of the most recent posedge
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          done_edge;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'(d[62:52]);
    if (e <= 896) return {d[63], 31'b0};
    return {d[63], 8'(e - 1023 + 127), d[51:29]};
  endfunction

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'h00) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  // Datapath model: LAT-1 enable-gated delay stages of cos(x), then an
  // accumulator that restarts on the sample flagged by pipe_n
  real dc[LAT-1];
  bit  dn[LAT-1];
  real acc = 0.0;

  always @(posedge clock) begin
    if (bus.pipe_en) begin
      acc <= dn[LAT-2] ? dc[LAT-2] : acc + dc[LAT-2];
      for (int i = LAT - 2; i > 0; i--) begin
        dc[i] <= dc[i-1];
        dn[i] <= dn[i-1];
      end
      dc[0] <= $cos(f2r(bus.pipe_x));
      dn[0] <= bus.pipe_n;
    end
  end

  assign bus.pipe_r = r2f(acc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding job
  always @(negedge clock) begin
    exp_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: done at edge %0d with no job pending", cyc + 1);
      end else begin
        e = sb.pop_front();
        check("result", bus.result, e.res);
        check("done_edge", 32'(cyc + 1), 32'(e.done_edge));
      end
    end
  end

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 9) == 0) return 32'h0000_0000;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 130)), 23'($urandom)};
  endfunction

  // Issue one job and feed its samples. Expected sum and done edge come
  // from plain arithmetic over the samples and the gap pattern.
  task automatic run_job(input int len, input int gap, input bit rand_gaps, input bit zeros,
                         input bit expect_done, input bit use_const, input logic [31:0] cval,
                         input bit idle_sample, output int t_cmd, output int t_done);
    logic [31:0] xs[$];
    int          gs[$];
    int          sumg = 0;
    int          waited = 0;
    real         s = 0.0;
    exp_t        e;
    for (int i = 0; i < len; i++) begin
      logic [31:0] x;
      int          g;
      x = zeros ? 32'h0000_0000 : rand_fp();
      g = rand_gaps ? int'($urandom_range(0, gap)) : ((i == 0) ? 0 : gap);
      xs.push_back(x);
      gs.push_back(g);
      sumg += g;
      s = s + $cos(f2r(x));
    end
    e.res = use_const ? cval : r2f(s);

    bus.cmd_valid = 1'b1;
    bus.cmd_len   = CNT_W'(len);
    while (!bus.cmd_ready && waited < 1000) begin
      @(negedge clock);
      waited++;
    end
    if (!bus.cmd_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_accept_timeout: cmd_ready still %b after %0d cycles", bus.cmd_ready, waited);
      bus.cmd_valid = 1'b0;
      t_cmd  = 0;
      t_done = 0;
      return;
    end
    t_cmd  = cyc + 1;
    t_done = t_cmd + ((len == 0) ? 1 : (len + sumg + LAT + 1));
    e.done_edge = t_done;
    if (expect_done) sb.push_back(e);

    if (idle_sample) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h3F80_0000;
      #1;
      check("pipe_en_in_idle", 32'(bus.pipe_en), 32'd0);
    end
    @(negedge clock);
    bus.cmd_valid = 1'b0;
    bus.in_valid  = 1'b0;

    for (int i = 0; i < len; i++) begin
      repeat (gs[i]) @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_data  = xs[i];
      #1;
      check("in_ready_feed", 32'(bus.in_ready), 32'd1);
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tc, td;
    logic any_rdy;
    int waited;

    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;

    repeat (3) @(negedge clock);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_pipe_en",   32'(bus.pipe_en),   32'd0);
    check("rst_pipe_n",    32'(bus.pipe_n),    32'd0);
    check("rst_pipe_x",    bus.pipe_x,         32'h0);
    check("rst_result",    bus.result,         32'h0);
    check("rst_done",      32'(bus.done),      32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Four zeros back to back, with a sample offered alongside the command
    run_job(4, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4080_0000, 1'b1, ta, tb);

    // Restart isolation between consecutive jobs
    run_job(1, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3F80_0000, 1'b0, ta, tb);
    run_job(2, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 1'b0, ta, tb);

    // Empty job
    run_job(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, ta, tb);
    any_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      any_rdy |= bus.in_ready;
      @(negedge clock);
    end
    check("in_ready_len0", 32'(any_rdy), 32'd0);

    // Five-cycle gaps between three samples
    run_job(3, 5, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4040_0000, 1'b0, ta, tb);

    // Abort 20 cycles into the drain
    run_job(3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ta, tb);
    repeat (20) @(negedge clock);
    check("busy_in_drain", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_result",    bus.result,         32'h0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("abort_busy",      32'(bus.busy),      32'd0);
    run_job(2, 0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4000_0000, 1'b0, ta, tb);

    // Command held while busy: second job accepted the edge after done
    run_job(2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, ta, tb);
    run_job(3, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, tc, td);
    check("held_cmd_accept_edge", 32'(tc), 32'(tb + 1));

    // Randomized jobs: lengths, gaps, sample values
    for (int j = 0; j < 10; j++) begin
      run_job(int'($urandom_range(0, 6)), 3, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,
              1'($urandom_range(0, 1)), ta, tb);
    end

    waited = 0;
    while (sb.size() != 0 && waited < 500) begin
      @(negedge clock);
      waited++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d jobs still pending, expected 0", sb.size());
    end
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
